// File: rtl/m_ifetch_ireg_pkg.sv
// m_ifetch_ireg_pkg: shared midgetv constants for the fetch / instruction-register stage.
package m_ifetch_ireg_pkg;
   typedef enum logic [1:0] {BOOT, IDLE, BUS} state_t;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam logic [3:0] MCAUSE_INSTR_ACCESS_FAULT = 4'd1;
endpackage

// File: rtl/m_ifetch_ireg_if.sv
// m_ifetch_ireg_if: Wishbone classic read-only bus between the fetch stage and instruction memory.
interface m_ifetch_ireg_if;
   logic CYC_O;
   logic STB_O;
   logic [29:0] ADR_O;
   logic [31:0] DAT_I;
   logic ACK_I;
   logic ERR_I;
   modport master(output CYC_O, STB_O, ADR_O, input DAT_I, ACK_I, ERR_I);
   modport slave(input CYC_O, STB_O, ADR_O, output DAT_I, ACK_I, ERR_I);
endinterface

// File: rtl/m_ifetch_ireg_wdog.sv
// m_ifetch_wdog: bus-cycle watchdog; expired flags the last allowed cycle, TIMEOUT=0 disables it.
module m_ifetch_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [7:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && cnt != 8'hff) cnt <= cnt + 8'd1;
   assign expired = (TIMEOUT != 0) && (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/m_ifetch_ireg.sv
// m_ifetch_ireg: midgetv instruction fetch over Wishbone classic, holding INSTR for the decoder.
module m_ifetch_ireg
   import m_ifetch_ireg_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int BOOT_DELAY = 2,
   parameter int TIMEOUT = 16
) (
   input  logic CLK_I,
   input  logic RST_I,
   input  logic fetch_req,
   input  logic [29:0] fetch_pc,
   output logic fetch_ready,
   m_ifetch_ireg_if.master wb,
   output logic [31:0] INSTR,
   output logic instr_valid,
   output logic corerunning,
   output logic fetch_fault,
   output logic fault_timeout,
   output logic [29:0] fault_adr
);
   state_t state;
   logic [3:0] bootcnt;
   logic expired;
   m_ifetch_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk(CLK_I),
      .rst(RST_I),
      .clear(state != BUS),
      .enable(state == BUS),
      .expired(expired)
   );
   assign fetch_ready = state == IDLE;
   assign wb.STB_O = wb.CYC_O;
   always_ff @(posedge CLK_I or posedge RST_I)
      if (RST_I) begin
         state <= BOOT;
         bootcnt <= 4'(BOOT_DELAY);
         wb.CYC_O <= 1'b0;
         wb.ADR_O <= RESET_PC[31:2];
         INSTR <= NOP_INSTR;
         instr_valid <= 1'b0;
         corerunning <= 1'b0;
         fetch_fault <= 1'b0;
         fault_timeout <= 1'b0;
         fault_adr <= '0;
      end else begin
         case (state)
            BOOT: begin
               bootcnt <= bootcnt - 4'd1;
               if (bootcnt == 4'd1) begin
                  corerunning <= 1'b1;
                  wb.CYC_O <= 1'b1;
                  state <= BUS;
               end
            end
            IDLE: if (fetch_req) begin
               wb.ADR_O <= fetch_pc;
               wb.CYC_O <= 1'b1;
               instr_valid <= 1'b0;
               fetch_fault <= 1'b0;
               fault_timeout <= 1'b0;
               state <= BUS;
            end
            BUS: begin
               // ERR_I outranks ACK_I, and a real ACK outranks the watchdog
               if (wb.ERR_I || (!wb.ACK_I && expired)) begin
                  wb.CYC_O <= 1'b0;
                  fetch_fault <= 1'b1;
                  fault_timeout <= !wb.ERR_I;
                  fault_adr <= wb.ADR_O;
                  state <= IDLE;
               end else if (wb.ACK_I) begin
                  INSTR <= wb.DAT_I;
                  instr_valid <= 1'b1;
                  wb.CYC_O <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= BOOT;
         endcase
      end
endmodule

// File: tb/tb_m_ifetch_ireg.sv
// tb_m_ifetch_ireg: directed checks of boot, fetch, wait states, faults, timeout and mid-bus reset.
module tb_m_ifetch_ireg;
   logic clk = 1'b0;
   logic rst;
   logic fetch_req;
   logic [29:0] fetch_pc;
   logic fetch_ready;
   logic [31:0] INSTR;
   logic instr_valid, corerunning, fetch_fault, fault_timeout;
   logic [29:0] fault_adr;
   int n_checks = 0;
   int n_fail = 0;
   m_ifetch_ireg_if wb();
   m_ifetch_ireg #(.RESET_PC(32'h00000100), .BOOT_DELAY(2), .TIMEOUT(4)) dut (
      .CLK_I(clk),
      .RST_I(rst),
      .fetch_req(fetch_req),
      .fetch_pc(fetch_pc),
      .fetch_ready(fetch_ready),
      .wb(wb),
      .INSTR(INSTR),
      .instr_valid(instr_valid),
      .corerunning(corerunning),
      .fetch_fault(fetch_fault),
      .fault_timeout(fault_timeout),
      .fault_adr(fault_adr)
   );
   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      fetch_req = 1'b0;
      fetch_pc = '0;
      wb.ACK_I = 1'b0;
      wb.ERR_I = 1'b0;
      wb.DAT_I = '0;
      tick();
      tick();
      n_checks++;
      if ({wb.CYC_O, wb.STB_O, instr_valid, corerunning, fetch_fault, fault_timeout, fetch_ready} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 0000000", {wb.CYC_O, wb.STB_O, instr_valid, corerunning, fetch_fault, fault_timeout, fetch_ready});
      end
      n_checks++;
      if (INSTR !== 32'h00000013) begin n_fail++; $display("FAIL reset_instr got %h want 00000013", INSTR); end
      n_checks++;
      if (wb.ADR_O !== 30'h40 || fault_adr !== 30'h0) begin
         n_fail++;
         $display("FAIL reset_adr got adr=%h fault_adr=%h want 40/0", wb.ADR_O, fault_adr);
      end
   endtask
   task automatic test_boot();
      rst = 1'b0;
      fetch_req = 1'b1;
      fetch_pc = 30'h3ff;
      tick();
      n_checks++;
      if ({corerunning, wb.CYC_O} !== 2'b00) begin n_fail++; $display("FAIL boot_edge1 got run/cyc=%b want 00", {corerunning, wb.CYC_O}); end
      tick();
      fetch_req = 1'b0;
      n_checks++;
      if ({corerunning, wb.CYC_O, wb.STB_O, fetch_ready} !== 4'b1110) begin
         n_fail++;
         $display("FAIL boot_edge2 got run/cyc/stb/rdy=%b want 1110", {corerunning, wb.CYC_O, wb.STB_O, fetch_ready});
      end
      n_checks++;
      if (wb.ADR_O !== 30'h40) begin n_fail++; $display("FAIL boot_adr got %h want 40", wb.ADR_O); end
      wb.ACK_I = 1'b1;
      wb.DAT_I = 32'h00500093;
      tick();
      wb.ACK_I = 1'b0;
      n_checks++;
      if (INSTR !== 32'h00500093) begin n_fail++; $display("FAIL boot_instr got %h want 00500093", INSTR); end
      n_checks++;
      if ({instr_valid, fetch_ready, wb.CYC_O} !== 3'b110) begin
         n_fail++;
         $display("FAIL boot_done got valid/rdy/cyc=%b want 110", {instr_valid, fetch_ready, wb.CYC_O});
      end
   endtask
   task automatic test_wait_states();
      int cyc_cnt = 0;
      fetch_req = 1'b1;
      fetch_pc = 30'h41;
      tick();
      fetch_req = 1'b0;
      n_checks++;
      if ({wb.CYC_O, instr_valid, fetch_ready} !== 3'b100 || wb.ADR_O !== 30'h41) begin
         n_fail++;
         $display("FAIL ws_accept got cyc/valid/rdy=%b adr=%h want 100/41", {wb.CYC_O, instr_valid, fetch_ready}, wb.ADR_O);
      end
      for (int i = 0; i < 3; i++) begin
         if (wb.CYC_O) cyc_cnt++;
         fetch_req = (i != 2);
         fetch_pc = 30'h7;
         wb.DAT_I = 32'h12345678;
         tick();
         n_checks++;
         if (INSTR !== 32'h00500093 || wb.ADR_O !== 30'h41 || wb.CYC_O !== 1'b1) begin
            n_fail++;
            $display("FAIL ws_wait%0d got instr=%h adr=%h cyc=%b want 00500093/41/1", i, INSTR, wb.ADR_O, wb.CYC_O);
         end
      end
      fetch_req = 1'b0;
      if (wb.CYC_O) cyc_cnt++;
      wb.ACK_I = 1'b1;
      wb.DAT_I = 32'h00A00113;
      tick();
      wb.ACK_I = 1'b0;
      if (wb.CYC_O) cyc_cnt++;
      n_checks++;
      if (cyc_cnt !== 4) begin n_fail++; $display("FAIL ws_cyc_len got %0d want 4", cyc_cnt); end
      n_checks++;
      if (INSTR !== 32'h00A00113 || {instr_valid, fetch_fault, fetch_ready} !== 3'b101) begin
         n_fail++;
         $display("FAIL ws_ack got instr=%h valid/fault/rdy=%b want 00a00113/101", INSTR, {instr_valid, fetch_fault, fetch_ready});
      end
      tick();
      n_checks++;
      if (wb.CYC_O !== 1'b0 || wb.ADR_O !== 30'h41) begin
         n_fail++;
         $display("FAIL ws_no_queue got cyc=%b adr=%h want 0/41", wb.CYC_O, wb.ADR_O);
      end
   endtask
   task automatic test_err();
      fetch_req = 1'b1;
      fetch_pc = 30'h55;
      tick();
      fetch_req = 1'b0;
      wb.ERR_I = 1'b1;
      wb.DAT_I = 32'h0BADF00D;
      tick();
      wb.ERR_I = 1'b0;
      n_checks++;
      if ({wb.CYC_O, fetch_fault, fault_timeout, instr_valid, fetch_ready} !== 5'b01001 || fault_adr !== 30'h55) begin
         n_fail++;
         $display("FAIL err_flags got cyc/flt/to/valid/rdy=%b adr=%h want 01001/55", {wb.CYC_O, fetch_fault, fault_timeout, instr_valid, fetch_ready}, fault_adr);
      end
      n_checks++;
      if (INSTR !== 32'h00A00113) begin n_fail++; $display("FAIL err_instr got %h want 00a00113", INSTR); end
      fetch_req = 1'b1;
      fetch_pc = 30'h56;
      tick();
      fetch_req = 1'b0;
      n_checks++;
      if ({fetch_fault, wb.CYC_O} !== 2'b01 || wb.ADR_O !== 30'h56) begin
         n_fail++;
         $display("FAIL err_clear got flt/cyc=%b adr=%h want 01/56", {fetch_fault, wb.CYC_O}, wb.ADR_O);
      end
      wb.ACK_I = 1'b1;
      wb.DAT_I = 32'h00000073;
      tick();
      wb.ACK_I = 1'b0;
      n_checks++;
      if (INSTR !== 32'h00000073 || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL err_refetch got instr=%h valid=%b want 00000073/1", INSTR, instr_valid);
      end
   endtask
   task automatic test_timeout();
      fetch_req = 1'b1;
      fetch_pc = 30'h60;
      tick();
      fetch_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (wb.CYC_O !== 1'b1) begin n_fail++; $display("FAIL to_hold%0d got cyc=%b want 1", i, wb.CYC_O); end
      end
      tick();
      n_checks++;
      if ({wb.CYC_O, fetch_fault, fault_timeout, instr_valid} !== 4'b0110 || fault_adr !== 30'h60) begin
         n_fail++;
         $display("FAIL to_fire got cyc/flt/to/valid=%b adr=%h want 0110/60", {wb.CYC_O, fetch_fault, fault_timeout, instr_valid}, fault_adr);
      end
      wb.ACK_I = 1'b1;
      wb.DAT_I = 32'hCAFEBABE;
      tick();
      wb.ACK_I = 1'b0;
      n_checks++;
      if (INSTR !== 32'h00000073 || {instr_valid, fetch_fault, fault_timeout} !== 3'b011) begin
         n_fail++;
         $display("FAIL to_late_ack got instr=%h valid/flt/to=%b want 00000073/011", INSTR, {instr_valid, fetch_fault, fault_timeout});
      end
   endtask
   task automatic test_ack_err();
      fetch_req = 1'b1;
      fetch_pc = 30'h70;
      tick();
      fetch_req = 1'b0;
      wb.ACK_I = 1'b1;
      wb.ERR_I = 1'b1;
      wb.DAT_I = 32'hDEADBEEF;
      tick();
      wb.ACK_I = 1'b0;
      wb.ERR_I = 1'b0;
      n_checks++;
      if (INSTR !== 32'h00000073 || {fetch_fault, fault_timeout, instr_valid, wb.CYC_O} !== 4'b1000 || fault_adr !== 30'h70) begin
         n_fail++;
         $display("FAIL ackerr got instr=%h flt/to/valid/cyc=%b adr=%h want 00000073/1000/70", INSTR, {fetch_fault, fault_timeout, instr_valid, wb.CYC_O}, fault_adr);
      end
   endtask
   task automatic test_reset_mid_bus();
      fetch_req = 1'b1;
      fetch_pc = 30'h80;
      tick();
      fetch_req = 1'b0;
      #2;
      wb.ACK_I = 1'b1;
      wb.DAT_I = 32'h11111111;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({wb.CYC_O, corerunning, fetch_fault} !== 3'b000 || INSTR !== 32'h00000013 || wb.ADR_O !== 30'h40) begin
         n_fail++;
         $display("FAIL rst_async got cyc/run/flt=%b instr=%h adr=%h want 000/00000013/40", {wb.CYC_O, corerunning, fetch_fault}, INSTR, wb.ADR_O);
      end
      tick();
      rst = 1'b0;
      wb.ACK_I = 1'b0;
      tick();
      n_checks++;
      if ({corerunning, wb.CYC_O, INSTR == 32'h00000013} !== 3'b001) begin
         n_fail++;
         $display("FAIL rst_reboot1 got run/cyc=%b instr=%h want 00/00000013", {corerunning, wb.CYC_O}, INSTR);
      end
      tick();
      n_checks++;
      if ({corerunning, wb.CYC_O} !== 2'b11 || wb.ADR_O !== 30'h40) begin
         n_fail++;
         $display("FAIL rst_reboot2 got run/cyc=%b adr=%h want 11/40", {corerunning, wb.CYC_O}, wb.ADR_O);
      end
      wb.ACK_I = 1'b1;
      wb.DAT_I = 32'h00100093;
      tick();
      wb.ACK_I = 1'b0;
      n_checks++;
      if (INSTR !== 32'h00100093 || instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_refetch got instr=%h valid=%b want 00100093/1", INSTR, instr_valid);
      end
   endtask
   initial begin
      test_reset();
      test_boot();
      test_wait_states();
      test_err();
      test_timeout();
      test_ack_err();
      test_reset_mid_bus();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
